// File: rtl/btn_sched_pkg.sv
// Shared defaults, width helper and index type for the button event scheduler.
// Optional drop counter is enabled in the top with BTN_DROP_CNT_EN.
package btn_sched_pkg;

  localparam int NUM_BTN_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  // Minimum bits to index 'value' entries; returns at least 1.
  function automatic int clog2_f(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int ID_W_DEF = clog2_f(NUM_BTN_DEF);

  typedef logic [ID_W_DEF-1:0] btn_id_t;

endpackage

// File: rtl/btn_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins,
// wrapping modulo NUM_BTN. The pointer register lives in the parent.
module btn_rr_arbiter
  import btn_sched_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF,
  parameter int ID_W    = clog2_f(NUM_BTN)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_BTN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Serialises one-cycle button press pulses into a valid/ready stream of button
// indices. Define BTN_DROP_CNT_EN to add the saturating drop_cnt port.
module button_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int NUM_BTN    = NUM_BTN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ID_W       = clog2_f(NUM_BTN)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready
`ifdef BTN_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt
`endif
);

  localparam int PTR_W = clog2_f(FIFO_DEPTH);

  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] gnt_mask;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               pop;
  logic               space;

  logic [ID_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  // Handshake: an event transfers on a clk edge where evt_valid && evt_ready;
  // evt_id is stable while evt_valid is high and not accepted.
  assign evt_valid = (count != '0);
  assign evt_id    = mem[rd_ptr];
  assign pop       = evt_valid & evt_ready;
  // A full queue may still accept a push in the same cycle it pops.
  assign space     = (count < (PTR_W+1)'(FIFO_DEPTH)) || pop;

  btn_rr_arbiter #(
    .NUM_BTN (NUM_BTN),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .en        (space),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign gnt_mask = gnt_valid ? (NUM_BTN'(1) << gnt_id) : '0;

  always_ff @(posedge clk) begin
    if (resetn) begin
      pending <= '0;
      rr_ptr  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      // A new pulse on the granted index re-arms it as a fresh event.
      pending <= (pending & ~gnt_mask) | btn_pulse;
      if (gnt_valid) begin
        mem[wr_ptr] <= gnt_id;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        rr_ptr      <= (gnt_id == ID_W'(NUM_BTN - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({gnt_valid, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef BTN_DROP_CNT_EN
  logic merge;

  // Press on an already-pending, ungranted button folds into the existing event.
  assign merge = |(btn_pulse & pending & ~gnt_mask);

  always_ff @(posedge clk) begin
    if (resetn) begin
      drop_cnt <= '0;
    end else if (merge && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler; drop counter steps run when
// BTN_DROP_CNT_EN is defined.
module tb_button_event_scheduler;

  logic       clk;
  logic       resetn;
  logic [3:0] btn_pulse;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
`ifdef BTN_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_cmp;
  int n_fail;
  logic [1:0] exp_q[$];

  button_event_scheduler #(
    .NUM_BTN    (4),
    .FIFO_DEPTH (4),
    .ID_W       (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_pulse (btn_pulse),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready)
`ifdef BTN_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] p);
    btn_pulse = p;
    tick();
    btn_pulse = 4'b0000;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Head must match the expected queue front, then it is popped (ready held high).
  task automatic drain(input string tag);
    logic [1:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(evt_valid), 32'd1);
      check({tag, "_id"}, 32'(evt_id), 32'(e));
      tick();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    resetn    = 1'b1;
    btn_pulse = 4'b0000;
    evt_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b0;

    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_count", 32'(dut.count), 32'd0);
`ifdef BTN_DROP_CNT_EN
    check("rst_drop", 32'(drop_cnt), 32'd0);
`endif

    // 1: single press, two-cycle latency, one-cycle event
    evt_ready = 1'b1;
    pulse(4'b0100);
    check("t1_lat1_valid", 32'(evt_valid), 32'd0);
    check("t1_pend", 32'(dut.pending), 32'h4);
    tick();
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_id", 32'(evt_id), 32'd2);
    tick();
    check("t1_gone", 32'(evt_valid), 32'd0);

    // 2: all four at once from rr_ptr=0
    do_reset();
    evt_ready = 1'b1;
    pulse(4'b1111);
    tick();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    drain("t2");
    check("t2_empty", 32'(evt_valid), 32'd0);
    check("t2_rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // 3: blocked consumer, btn0 pressed again while queue full
    do_reset();
    evt_ready = 1'b0;
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    pulse(4'b1000);
    pulse(4'b0001);
    tick();
    check("t3_count", 32'(dut.count), 32'd4);
    check("t3_pend", 32'(dut.pending), 32'h1);
    check("t3_head", 32'(evt_id), 32'd0);
    evt_ready = 1'b1;
    tick();
    check("t3_count_after_pop", 32'(dut.count), 32'd4);
    check("t3_pend_after_pop", 32'(dut.pending), 32'h0);
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0};
    drain("t3");
    check("t3_empty", 32'(evt_valid), 32'd0);

    // 4: full queue, pop and push of pending btn1 in the same cycle
    do_reset();
    evt_ready = 1'b0;
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    pulse(4'b1000);
    pulse(4'b0010);
    check("t4_count_full", 32'(dut.count), 32'd4);
    check("t4_pend", 32'(dut.pending), 32'h2);
    evt_ready = 1'b1;
    tick();
    check("t4_count", 32'(dut.count), 32'd4);
    check("t4_pend_clr", 32'(dut.pending), 32'h0);
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd1};
    drain("t4");
    check("t4_empty", 32'(evt_valid), 32'd0);

`ifdef BTN_DROP_CNT_EN
    // 5: merged presses on btn3 while blocked
    do_reset();
    evt_ready = 1'b0;
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    pulse(4'b1000);
    pulse(4'b1000);
    check("t5_no_drop_yet", 32'(drop_cnt), 32'd0);
    pulse(4'b1000);
    check("t5_drop1", 32'(drop_cnt), 32'd1);
    btn_pulse = 4'b1000;
    for (int i = 0; i < 300; i++) tick();
    btn_pulse = 4'b0000;
    check("t5_drop_sat", 32'(drop_cnt), 32'd255);
`endif

    // 6: reset mid-stream discards queued and pending events
    do_reset();
    evt_ready = 1'b0;
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    check("t6_count_pre", 32'(dut.count), 32'd2);
    do_reset();
    check("t6_valid", 32'(evt_valid), 32'd0);
    check("t6_pend", 32'(dut.pending), 32'h0);
    check("t6_id", 32'(evt_id), 32'd0);
    evt_ready = 1'b1;
    tick();
    check("t6_valid_1", 32'(evt_valid), 32'd0);
    tick();
    check("t6_valid_2", 32'(evt_valid), 32'd0);
    check("t6_id_2", 32'(evt_id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
